program_sequencer: RTL and testbench

- Generates the program-memory address stream consumed by the instruction decoder.
- The synchronous program memory returns next_instr one cycle after pm_addr; the decoder registers it into ir.
- Applies jmp / jmp_nz decisions coming back from the decoder and the ALU zero flag.
- Owns reset sequencing: converts the asynchronous active-low board reset into the synchronous sync_reset the rest of the core uses.
- Adds hold (stall) and self-jump halt detection, plus a retired-instruction counter for debug.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/reset_sync.sv | 24 ++
 rtl/program_sequencer.sv | 110 +++++++++++
 tb/tb_program_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the CPU core: FSM encodings and address widths.
package cpu_pkg;

  localparam int PC_W   = 8;
  localparam int PAGE_W = 4;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on clk.
module reset_sync (
  input  logic clk,
  input  logic rst_async_n_i,
  output logic rst_sync_n_o
);

  logic meta_q;
  logic sync_q;

  // Shift a 1 through two flops after the asynchronous reset releases.
  always_ff @(posedge clk or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign rst_sync_n_o = sync_q;

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: drives the program-memory address stream, applies
// page-local jumps, stalls on hold, detects self-jump halts and counts
// issued instructions.
//
// state | meaning
// RST   | sync_reset high; waits RST_CYC clocks after synchronised release
// RUN   | issuing pc+1 or jump targets
// HOLD  | stalled; pc frozen until hold drops
// HALT  | self-jump seen; pc frozen until reset_n
module program_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int RST_CYC = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jmp,
  input  logic              jmp_nz,
  input  logic [PAGE_W-1:0] jmp_addr,
  input  logic              dont_jmp,
  input  logic              hold,
  output logic              sync_reset,
  output logic [PC_W-1:0]   pm_addr,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam int RCW = $clog2(RST_CYC);

  state_t             state_q;
  logic [RCW-1:0]     rst_cnt_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pm_addr_d;
  logic [CNT_W-1:0]   instr_cnt_q;
  logic               rst_sync_n;
  logic               take;
  logic [PC_W-1:0]    tgt;

  reset_sync u_reset_sync (
    .clk           (clk),
    .rst_async_n_i (reset_n),
    .rst_sync_n_o  (rst_sync_n)
  );

  assign take       = jmp | (jmp_nz & ~dont_jmp);
  assign tgt        = {pc_q[PC_W-1:PAGE_W], jmp_addr};
  assign sync_reset = (state_q == ST_RST);

  // Next program-memory address, in priority order.
  always_comb begin
    pm_addr_d = pc_q + PC_W'(1);
    if (sync_reset) begin
      pm_addr_d = '0;
    end else if ((state_q == ST_HALT) || hold) begin
      pm_addr_d = pc_q;
    end else if (take) begin
      pm_addr_d = tgt;
    end
  end

  // Sequencer FSM with reset counter, pc and retired-instruction counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RST;
      rst_cnt_q   <= RCW'(RST_CYC - 1);
      pc_q        <= '0;
      instr_cnt_q <= '0;
    end else begin
      pc_q <= pm_addr_d;
      if ((state_q == ST_RUN) && !hold && !sync_reset && (instr_cnt_q != '1)) begin
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_RST: begin
          if (rst_sync_n) begin
            if (rst_cnt_q == '0) begin
              state_q <= ST_RUN;
            end else begin
              rst_cnt_q <= rst_cnt_q - RCW'(1);
            end
          end
        end
        ST_RUN: begin
          if (hold) begin
            state_q <= ST_HOLD;
          end else if (take && (tgt == pc_q)) begin
            state_q <= ST_HALT;
          end
        end
        ST_HOLD: begin
          if (!hold) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign pm_addr   = pm_addr_d;
  assign pc        = pc_q;
  assign halted    = (state_q == ST_HALT);
  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer.
module tb_program_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        jmp, jmp_nz, dont_jmp, hold;
  logic [3:0]  jmp_addr;
  logic        sync_reset, halted;
  logic [7:0]  pm_addr, pc;
  logic [1:0]  state;
  logic [15:0] instr_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  bit running  = 1'b0;

  program_sequencer #(.PC_W(8), .RST_CYC(2), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .jmp_addr   (jmp_addr),
    .dont_jmp   (dont_jmp),
    .hold       (hold),
    .sync_reset (sync_reset),
    .pm_addr    (pm_addr),
    .pc         (pc),
    .halted     (halted),
    .state      (state),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the bench models instr_cnt by counting edges spent running.
  task automatic step();
    @(posedge clk);
    if (running) exp_cnt++;
    #1;
  endtask

  task automatic run_to(input logic [7:0] t);
    int n = 0;
    while (pc !== t && n < 400) begin
      step();
      n++;
    end
    chk("run_to_reached", {24'd0, pc}, {24'd0, t});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sync_reset"}, {31'd0, sync_reset}, 32'd1);
    chk({tag, "_pc"},         {24'd0, pc},         32'h00);
    chk({tag, "_halted"},     {31'd0, halted},     32'd0);
    chk({tag, "_cnt"},        {16'd0, instr_cnt},  32'd0);
    chk({tag, "_state"},      {30'd0, state},      32'(ST_RST));
    chk({tag, "_pm_addr"},    {24'd0, pm_addr},    32'h00);
  endtask

  initial begin
    reset_n = 1'b0; jmp = 0; jmp_nz = 0; dont_jmp = 0; hold = 0; jmp_addr = 4'h0;
    step(); step(); step();
    chk_reset_vals("por");

    // Release between edges; two edges of synchroniser, then RST_CYC=2 more.
    reset_n = 1'b1;
    step(); chk("rel_e1_sync_reset", {31'd0, sync_reset}, 32'd1);
    chk("rel_e1_pm_addr", {24'd0, pm_addr}, 32'h00);
    step(); chk("rel_e2_sync_reset", {31'd0, sync_reset}, 32'd1);
    step(); chk("rel_e3_sync_reset", {31'd0, sync_reset}, 32'd1);
    chk("rel_e3_pm_addr", {24'd0, pm_addr}, 32'h00);
    step(); chk("rel_e4_sync_reset", {31'd0, sync_reset}, 32'd0);
    chk("rel_e4_state", {30'd0, state}, 32'(ST_RUN));
    chk("rel_e4_pm_addr", {24'd0, pm_addr}, 32'h01);
    running = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("boot_pc", {24'd0, pc}, 32'(i));
      chk("boot_cnt", {16'd0, instr_cnt}, 32'(i));
    end

    // Jumps within page 3.
    run_to(8'h35);
    jmp = 1; jmp_addr = 4'hA; #1;
    chk("jmp_pm_addr", {24'd0, pm_addr}, 32'h3A);
    step(); chk("jmp_pc", {24'd0, pc}, 32'h3A);
    jmp = 0; jmp_nz = 1; dont_jmp = 1; #1;
    chk("jnz_not_taken_pm", {24'd0, pm_addr}, 32'h3B);
    step(); chk("jnz_not_taken_pc", {24'd0, pc}, 32'h3B);
    dont_jmp = 0; jmp_addr = 4'h2; #1;
    chk("jnz_taken_pm", {24'd0, pm_addr}, 32'h32);
    step(); chk("jnz_taken_pc", {24'd0, pc}, 32'h32);
    chk("jnz_no_halt", {31'd0, halted}, 32'd0);
    chk("jnz_state", {30'd0, state}, 32'(ST_RUN));
    jmp_nz = 0;
    chk("cnt_after_jumps", {16'd0, instr_cnt}, 32'(exp_cnt));

    // Address wrap.
    run_to(8'hFE);
    step(); chk("wrap_pc_ff", {24'd0, pc}, 32'hFF);
    chk("wrap_pm_00", {24'd0, pm_addr}, 32'h00);
    step(); chk("wrap_pc_00", {24'd0, pc}, 32'h00);
    step(); chk("wrap_pc_01", {24'd0, pc}, 32'h01);
    chk("wrap_halted", {31'd0, halted}, 32'd0);

    // Hold with a pending jump.
    run_to(8'h10);
    hold = 1; jmp = 1; jmp_addr = 4'h4; running = 1'b0; #1;
    chk("hold_pm", {24'd0, pm_addr}, 32'h10);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_pc", {24'd0, pc}, 32'h10);
      chk("hold_state", {30'd0, state}, 32'(ST_HOLD));
      chk("hold_cnt", {16'd0, instr_cnt}, 32'(exp_cnt));
    end
    hold = 0; #1;
    chk("unhold_pm", {24'd0, pm_addr}, 32'h14);
    step(); chk("unhold_pc", {24'd0, pc}, 32'h14);
    chk("unhold_state", {30'd0, state}, 32'(ST_RUN));
    chk("unhold_cnt", {16'd0, instr_cnt}, 32'(exp_cnt));
    running = 1'b1; jmp = 0;

    // Self-jump halt.
    run_to(8'h27);
    jmp = 1; jmp_addr = 4'h7; #1;
    chk("self_pm", {24'd0, pm_addr}, 32'h27);
    step(); running = 1'b0;
    chk("halt_state", {30'd0, state}, 32'(ST_HALT));
    chk("halt_flag", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      jmp = i[0]; jmp_addr = 4'h0;
      step();
      chk("halt_pc", {24'd0, pc}, 32'h27);
      chk("halt_cnt", {16'd0, instr_cnt}, 32'(exp_cnt));
    end
    chk("halt_pm", {24'd0, pm_addr}, 32'h27);
    jmp = 0;

    // Asynchronous reset in the middle of a HALT cycle.
    #3 reset_n = 1'b0; #1;
    chk_reset_vals("arst_halt");
    exp_cnt = 0;
    step(); reset_n = 1'b1;
    step(); step(); step(); step();
    chk("reboot_state", {30'd0, state}, 32'(ST_RUN));
    running = 1'b1;
    step(); step();
    chk("reboot_pc", {24'd0, pc}, 32'h02);
    chk("reboot_cnt", {16'd0, instr_cnt}, 32'(exp_cnt));

    // Asynchronous reset in the middle of a HOLD cycle.
    hold = 1; running = 1'b0;
    step();
    chk("hold2_state", {30'd0, state}, 32'(ST_HOLD));
    #3 reset_n = 1'b0; #1;
    chk_reset_vals("arst_hold");
    hold = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
